// File: rtl/lut_cfg_pkg.sv
// lut_cfg_pkg: shared state encoding and frame-size helpers for the LUT configuration loader
package lut_cfg_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_e;

    localparam int DEF_LUT_INPUTS = 4;
    localparam int INIT_W = 2 ** DEF_LUT_INPUTS;

    function automatic int frame_w(input int num_luts, input int lut_inputs);
        return num_luts * (2 ** lut_inputs);
    endfunction

endpackage

// File: rtl/lut_cfg_shifter.sv
// lut_cfg_shifter: shadow shift register, saturating bit counter and parity accumulator (parity when LUT_CFG_PARITY_EN)
module lut_cfg_shifter #(
    parameter int FRAME_W = 64,
    parameter int CW      = $clog2(FRAME_W + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               shift_en_i,
    input  logic               bit_i,
    output logic [FRAME_W-1:0] shadow_o,
`ifdef LUT_CFG_PARITY_EN
    output logic               parity_o,
`endif
    output logic [CW-1:0]      count_o
);

    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic [CW-1:0]      count_q, count_d;
`ifdef LUT_CFG_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // Next-state: shift in at the LSB, count saturates at FRAME_W, clear wins over shift
    always_comb begin
        shadow_d = clear_i ? '0 : shift_en_i ? {shadow_q[FRAME_W-2:0], bit_i} : shadow_q;
        count_d  = clear_i ? '0 : (shift_en_i && count_q != CW'(FRAME_W)) ? count_q + 1'b1 : count_q;
`ifdef LUT_CFG_PARITY_EN
        parity_d = clear_i ? 1'b0 : parity_q ^ (shift_en_i & bit_i);
`endif
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            count_q  <= '0;
`ifdef LUT_CFG_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            shadow_q <= shadow_d;
            count_q  <= count_d;
`ifdef LUT_CFG_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-cycle shadow is exported so a commit on the final data edge captures that edge's bit;
    // while no shift is happening it equals the registered shadow.
    assign shadow_o = shadow_d;
    assign count_o  = count_q;
`ifdef LUT_CFG_PARITY_EN
    assign parity_o = parity_q;
`endif

endmodule

// File: rtl/lut_config_loader.sv
// lut_config_loader: serial loader committing a bank of LUT INIT masks atomically (parity check when LUT_CFG_PARITY_EN)
module lut_config_loader
    import lut_cfg_pkg::*;
#(
    parameter int NUM_LUTS   = 4,
    parameter int LUT_INPUTS = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  start_i,
    input  logic                                  cfg_bit_i,
    input  logic                                  cfg_valid_i,
    output logic                                  cfg_ready_o,
    output logic [NUM_LUTS*(2**LUT_INPUTS)-1:0]   lut_init_o,
    output logic                                  busy_o,
    output logic                                  cfg_done_o,
    output logic                                  cfg_err_o
);

    localparam int FW = frame_w(NUM_LUTS, LUT_INPUTS);
    localparam int CW = $clog2(FW + 1);

    state_e          state_q, state_d;
    logic [FW-1:0]   lut_q, lut_d, shadow;
    logic [CW-1:0]   count;
    logic            busy, xfer, last, clear, shift_en, commit;
`ifdef LUT_CFG_PARITY_EN
    logic            parity, par_bad;
`endif

    assign busy     = (state_q == LOAD) || (state_q == CHECK);
    assign xfer     = cfg_valid_i && busy;
    assign last     = count == CW'(FW - 1);
    assign clear    = start_i && (state_q inside {IDLE, DONE, ERROR});
    assign shift_en = xfer && (state_q == LOAD);
`ifdef LUT_CFG_PARITY_EN
    assign par_bad  = parity ^ cfg_bit_i;
`endif

    lut_cfg_shifter #(.FRAME_W(FW), .CW(CW)) u_shifter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear),
        .shift_en_i (shift_en),
        .bit_i      (cfg_bit_i),
        .shadow_o   (shadow),
`ifdef LUT_CFG_PARITY_EN
        .parity_o   (parity),
`endif
        .count_o    (count)
    );

    // Next state and commit strobe; START only matters in the idle-like states
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: state_d = start_i ? LOAD : state_q;
`ifdef LUT_CFG_PARITY_EN
            LOAD:  state_d = (shift_en && last) ? CHECK : LOAD;
            CHECK: begin
                state_d = xfer ? (par_bad ? ERROR : DONE) : CHECK;
                commit  = xfer && !par_bad;
            end
`else
            LOAD: begin
                state_d = (shift_en && last) ? DONE : LOAD;
                commit  = shift_en && last;
            end
`endif
            default: state_d = IDLE;
        endcase
        lut_d = commit ? shadow : lut_q;
    end

    // FSM state and committed LUT masks; reset aborts any frame and clears the masks
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            lut_q   <= '0;
        end else begin
            state_q <= state_d;
            lut_q   <= lut_d;
        end
    end

    assign cfg_ready_o = busy;
    assign busy_o      = busy;
    assign cfg_done_o  = state_q == DONE;
    assign lut_init_o  = lut_q;
`ifdef LUT_CFG_PARITY_EN
    assign cfg_err_o   = state_q == ERROR;
`else
    assign cfg_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_lut_config_loader.sv
// tb_lut_config_loader: directed bench for lut_config_loader (parity tests when LUT_CFG_PARITY_EN)
module tb_lut_config_loader;

    localparam int NL = 2;
    localparam int LI = 4;
    localparam int FW = 32;

    logic          clk = 1'b0;
    logic          rst, start, cfg_bit, cfg_valid;
    logic          ready, busy, done, err;
    logic [FW-1:0] lut;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    lut_config_loader #(.NUM_LUTS(NL), .LUT_INPUTS(LI)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .cfg_bit_i   (cfg_bit),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (ready),
        .lut_init_o  (lut),
        .busy_o      (busy),
        .cfg_done_o  (done),
        .cfg_err_o   (err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start a frame and stream it MSB first; optionally gap valid and poke START mid-frame
    task automatic send_frame(input logic [31:0] d, input logic par, input bit gap, input bit poke,
                              input logic [31:0] prev);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("flags_after_start", {busy, ready, done, err}, 4'b1100);
        for (int i = FW - 1; i >= 0; i--) begin
            cfg_bit = d[i]; cfg_valid = 1'b1;
            @(negedge clk);
            if (gap) begin
                cfg_valid = 1'b0; cfg_bit = ~d[i]; start = poke && (i == 16);
                @(negedge clk);
                start = 1'b0;
            end
            if (i == 16) chk("lut_stable_mid", lut, prev);
        end
`ifdef LUT_CFG_PARITY_EN
        chk("busy_in_check", {busy, ready, done}, 3'b110);
        cfg_bit = par; cfg_valid = 1'b1;
        @(negedge clk);
`else
        if (par === 1'bx) $display("unexpected X parity argument");
`endif
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] m;
        rst = 1'b1; start = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
        // 1: reset with random inputs
        repeat (2) begin
            @(negedge clk);
            start = 1'($urandom); cfg_bit = 1'($urandom); cfg_valid = 1'($urandom);
        end
        @(negedge clk);
        chk("reset_lut", lut, 32'h0);
        chk("reset_flags", {ready, busy, done, err}, 4'b0000);
        rst = 1'b0; start = 1'b0; cfg_valid = 1'b0;
        @(negedge clk);
        chk("idle_flags", {ready, busy, done, err}, 4'b0000);

        // 2: good frame
        send_frame(32'h8000_6996, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("good_flags", {ready, busy, done, err}, 4'b0010);
        chk("good_lut", lut, 32'h8000_6996);
        m = lut[15:0];
        for (int a = 0; a < 16; a++) chk($sformatf("lut0_xor4_%0d", a), m[a], (a % 2) ^ ((a / 2) % 2) ^ ((a / 4) % 2) ^ (a / 8));
        m = lut[31:16];
        for (int a = 0; a < 16; a++) chk($sformatf("lut1_and4_%0d", a), m[a], a == 15);
        @(negedge clk);
        chk("done_held", {done, busy}, 2'b10);

`ifdef LUT_CFG_PARITY_EN
        // 3: bad parity keeps previous masks
        send_frame(32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_6996);
        chk("bad_flags", {ready, busy, done, err}, 4'b0001);
        chk("bad_lut_kept", lut, 32'h8000_6996);
        @(negedge clk);
        chk("err_held", err, 1'b1);
`endif

        // 4: gapped valid with START poked mid-frame, after a different frame
        send_frame(32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h8000_6996);
        chk("other_lut", lut, 32'h1234_5678);
        send_frame(32'h8000_6996, 1'b1, 1'b1, 1'b1, 32'h1234_5678);
        chk("gap_flags", {ready, busy, done, err}, 4'b0010);
        chk("gap_lut", lut, 32'h8000_6996);

        // 5: reset mid-frame, then a fresh frame
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cfg_bit = 1'($urandom); cfg_valid = 1'b1;
            @(negedge clk);
        end
        cfg_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_lut", lut, 32'h0);
        chk("midrst_flags", {ready, busy, done, err}, 4'b0000);
        send_frame(32'hA5C3_0F1E, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("fresh_flags", {done, err}, 2'b10);
        chk("fresh_lut", lut, 32'hA5C3_0F1E);

`ifndef LUT_CFG_PARITY_EN
        // 6: no parity bit, done one cycle after bit 32
        send_frame(32'hFFFF_0000, 1'b0, 1'b0, 1'b0, 32'hA5C3_0F1E);
        chk("nopar_flags", {ready, busy, done, err}, 4'b0010);
        chk("nopar_lut", lut, 32'hFFFF_0000);
        send_frame(32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'hFFFF_0000);
        chk("nopar_err_never", {done, err}, 2'b10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
